// File: rtl/ahb_bus_arbiter.sv
// Four-master AHB bus arbiter: one-hot grant held until the owner's burst ends.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (master 0 highest).
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic                   HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [31:0]            HADDR,
  input  logic [2:0]             HSIZE,
  input  logic [2:0]             HBURST,
  input  logic [1:0]             HRESP,
  input  logic                   TRANSCOMPLETE,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [1:0]             HMASTER
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_OWNED, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_hgrant, w_hgrant_nxt;
  logic [1:0]       r_hmaster, w_hmaster_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_idle1, w_idle1_nxt;
  logic [1:0]       w_winner;
  logic             w_any_req, w_idle_cond, w_timeout, w_release;
  logic             w_unused;

  // Address/size/burst are observed on the bus but never influence arbitration.
  assign w_unused = ^{HADDR, HSIZE, HBURST};

  function automatic logic [1:0] pick_fixed(input logic [3:0] req);
    pick_fixed = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) pick_fixed = 2'(i);
    end
  endfunction

  // Offsets are scanned from farthest to nearest so the nearest set bit after 'last' wins.
  function automatic logic [1:0] pick_rr(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    pick_rr = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) pick_rr = idx;
    end
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] r_rr_ptr;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_rr_ptr <= 2'd0;
    end else if (w_state_nxt == S_OWNED && r_state != S_OWNED) begin
      r_rr_ptr <= w_winner;
    end
  end

  assign w_winner = pick_rr(HBUSREQ, r_rr_ptr);
`else
  assign w_winner = pick_fixed(HBUSREQ);
`endif

  assign w_any_req   = |HBUSREQ;
  assign w_idle_cond = (HTRANS == 2'b00) && !HBUSREQ[r_hmaster];
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  assign w_release   = (TRANSCOMPLETE && !HLOCK) || (HRESP != 2'b00) ||
                       (w_idle_cond && r_idle1) || w_timeout;

  // GAP arbitrates like IDLE so the bus is parked for exactly one cycle between owners.
  always_comb begin
    w_state_nxt   = r_state;
    w_hgrant_nxt  = r_hgrant;
    w_hmaster_nxt = r_hmaster;
    w_cnt_nxt     = r_cnt;
    w_idle1_nxt   = r_idle1;
    case (r_state)
      S_IDLE, S_GAP: begin
        w_state_nxt  = S_IDLE;
        w_hgrant_nxt = 4'b0000;
        w_cnt_nxt    = '0;
        w_idle1_nxt  = 1'b0;
        if (w_any_req) begin
          w_state_nxt   = S_OWNED;
          w_hgrant_nxt  = 4'b0001 << w_winner;
          w_hmaster_nxt = w_winner;
        end
      end
      S_OWNED: begin
        if (w_release) begin
          w_state_nxt  = S_GAP;
          w_hgrant_nxt = 4'b0000;
          w_cnt_nxt    = '0;
          w_idle1_nxt  = 1'b0;
        end else begin
          w_cnt_nxt   = (TRANSCOMPLETE && HLOCK) ? '0 : r_cnt + 1'b1;
          w_idle1_nxt = w_idle_cond;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_hgrant_nxt = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state   <= S_IDLE;
      r_hgrant  <= 4'b0000;
      r_hmaster <= 2'd0;
      r_cnt     <= '0;
      r_idle1   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hgrant  <= w_hgrant_nxt;
      r_hmaster <= w_hmaster_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idle1   <= w_idle1_nxt;
    end
  end

  assign HGRANT  = r_hgrant;
  assign HMASTER = r_hmaster;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed, table-driven bench for ahb_bus_arbiter, plus a timeout sequence on a short-timeout instance.
module tb_ahb_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [3:0]  HBUSREQ;
  logic        HLOCK;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HRESP;
  logic        TRANSCOMPLETE;
  logic [3:0]  grant, grant_to;
  logic [1:0]  master, master_to;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(.NUM_MASTERS(4), .TIMEOUT_CYCLES(64)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HADDR(HADDR), .HSIZE(HSIZE), .HBURST(HBURST), .HRESP(HRESP),
    .TRANSCOMPLETE(TRANSCOMPLETE), .HGRANT(grant), .HMASTER(master)
  );

  ahb_bus_arbiter #(.NUM_MASTERS(4), .TIMEOUT_CYCLES(8)) u_dut_to (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HADDR(HADDR), .HSIZE(HSIZE), .HBURST(HBURST), .HRESP(HRESP),
    .TRANSCOMPLETE(TRANSCOMPLETE), .HGRANT(grant_to), .HMASTER(master_to)
  );

  typedef struct {
    string      name;
    logic       rstn;
    logic [3:0] req;
    logic       lock;
    logic [1:0] trans;
    logic [1:0] resp;
    logic       tc;
    logic [3:0] g;
    logic [1:0] m;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input string name, input logic rstn, input logic [3:0] req,
                     input logic lock, input logic [1:0] trans, input logic [1:0] resp,
                     input logic tc, input logic [3:0] g, input logic [1:0] m);
    vec_t v;
    v.name = name; v.rstn = rstn; v.req = req; v.lock = lock; v.trans = trans;
    v.resp = resp; v.tc = tc; v.g = g; v.m = m;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rstn, input logic [3:0] req, input logic lock,
                       input logic [1:0] trans, input logic [1:0] resp, input logic tc);
    HRESETn = rstn; HBUSREQ = req; HLOCK = lock; HTRANS = trans; HRESP = resp;
    TRANSCOMPLETE = tc;
    HADDR = $urandom; HSIZE = 3'($urandom_range(0, 7)); HBURST = 3'($urandom_range(0, 7));
  endtask

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] ag, input logic [3:0] eg,
                       input logic [1:0] am, input logic [1:0] em);
    n_tests++;
    if (ag !== eg || am !== em || !$onehot0(ag)) begin
      n_fail++;
      $display("FAIL %s: got HGRANT=%b HMASTER=%0d, want HGRANT=%b HMASTER=%0d",
               name, ag, am, eg, em);
    end
  endtask

  initial begin
    // name, rstn, req, lock, trans, resp, tc, exp grant, exp master
    add("rst1",        0, 4'b0000, 0, 2'b10, 2'b00, 0, 4'b0000, 2'd0);
    add("rst2",        0, 4'b0000, 0, 2'b10, 2'b00, 0, 4'b0000, 2'd0);
    add("grant_m3",    1, 4'b1000, 0, 2'b10, 2'b00, 0, 4'b1000, 2'd3);
    for (int i = 0; i < 10; i++)
      add("hold_m3",   1, 4'b1111, 0, 2'b10, 2'b00, 0, 4'b1000, 2'd3);
    add("tc_release",  1, 4'b1111, 0, 2'b10, 2'b00, 1, 4'b0000, 2'd3);
    add("regrant_m0",  1, 4'b1111, 0, 2'b10, 2'b00, 0, 4'b0001, 2'd0);
    add("tc_rel_m0",   1, 4'b0110, 0, 2'b10, 2'b00, 1, 4'b0000, 2'd0);
    add("pair_g1",     1, 4'b0110, 0, 2'b10, 2'b00, 0, 4'b0010, 2'd1);
    add("pair_tc1",    1, 4'b0110, 0, 2'b10, 2'b00, 1, 4'b0000, 2'd1);
    add("pair_g2",     1, 4'b0110, 0, 2'b10, 2'b00, 0, RR ? 4'b0100 : 4'b0010, RR ? 2'd2 : 2'd1);
    add("pair_tc2",    1, 4'b0110, 0, 2'b10, 2'b00, 1, 4'b0000, RR ? 2'd2 : 2'd1);
    add("pair_g3",     1, 4'b0110, 0, 2'b10, 2'b00, 0, 4'b0010, 2'd1);
    add("pair_tc3",    1, 4'b0110, 0, 2'b10, 2'b00, 1, 4'b0000, 2'd1);
    add("grant_m2",    1, 4'b0100, 0, 2'b10, 2'b00, 0, 4'b0100, 2'd2);
    add("lock_tc",     1, 4'b0100, 1, 2'b10, 2'b00, 1, 4'b0100, 2'd2);
    add("lock_hold",   1, 4'b0100, 1, 2'b10, 2'b00, 0, 4'b0100, 2'd2);
    add("err_release", 1, 4'b0100, 1, 2'b10, 2'b01, 0, 4'b0000, 2'd2);
    add("gap_resp",    1, 4'b0000, 0, 2'b10, 2'b01, 0, 4'b0000, 2'd2);
    add("idle_empty",  1, 4'b0000, 0, 2'b10, 2'b00, 1, 4'b0000, 2'd2);
    add("idle_resp",   1, 4'b0001, 0, 2'b10, 2'b10, 0, 4'b0001, 2'd0);
    add("retry_rel",   1, 4'b0001, 0, 2'b10, 2'b10, 0, 4'b0000, 2'd0);
    add("gap_grant",   1, 4'b0010, 0, 2'b10, 2'b00, 0, 4'b0010, 2'd1);
    add("split_rel",   1, 4'b0010, 0, 2'b10, 2'b11, 0, 4'b0000, 2'd1);
    add("grant_m3b",   1, 4'b1000, 0, 2'b10, 2'b00, 0, 4'b1000, 2'd3);
    add("idle_1st",    1, 4'b0000, 0, 2'b00, 2'b00, 0, 4'b1000, 2'd3);
    add("idle_2nd",    1, 4'b0000, 0, 2'b00, 2'b00, 0, 4'b0000, 2'd3);
    add("gap_to_idle", 1, 4'b0000, 0, 2'b00, 2'b00, 0, 4'b0000, 2'd3);
    add("grant_m2b",   1, 4'b0100, 0, 2'b10, 2'b00, 0, 4'b0100, 2'd2);
    add("idle_a",      1, 4'b0000, 0, 2'b00, 2'b00, 0, 4'b0100, 2'd2);
    add("idle_break",  1, 4'b0000, 0, 2'b10, 2'b00, 0, 4'b0100, 2'd2);
    add("idle_b",      1, 4'b0000, 0, 2'b00, 2'b00, 0, 4'b0100, 2'd2);
    add("idle_c_rel",  1, 4'b0000, 0, 2'b00, 2'b00, 0, 4'b0000, 2'd2);
    add("back_idle",   1, 4'b0000, 0, 2'b10, 2'b00, 0, 4'b0000, 2'd2);
    add("grant_m1",    1, 4'b0010, 0, 2'b10, 2'b00, 0, 4'b0010, 2'd1);
    add("rst_mid",     0, 4'b0010, 0, 2'b10, 2'b00, 0, 4'b0000, 2'd0);
    add("after_rst",   1, 4'b0010, 0, 2'b10, 2'b00, 0, 4'b0010, 2'd1);
    add("final_tc",    1, 4'b0010, 0, 2'b10, 2'b00, 1, 4'b0000, 2'd1);

    drive(1'b0, 4'b0000, 1'b0, 2'b10, 2'b00, 1'b0);
    foreach (vecs[i]) begin
      drive(vecs[i].rstn, vecs[i].req, vecs[i].lock, vecs[i].trans, vecs[i].resp, vecs[i].tc);
      step();
      check(vecs[i].name, grant, vecs[i].g, master, vecs[i].m);
    end

    // Timeout: the 8-cycle instance releases 8 edges after grant, the 64-cycle one holds.
    drive(1'b0, 4'b0000, 1'b0, 2'b10, 2'b00, 1'b0);
    step();
    step();
    drive(1'b1, 4'b0001, 1'b0, 2'b10, 2'b00, 1'b0);
    step();
    check("to_grant", grant_to, 4'b0001, master_to, 2'd0);
    for (int i = 1; i <= 7; i++) begin
      step();
      check("to_hold", grant_to, 4'b0001, master_to, 2'd0);
    end
    step();
    check("to_release", grant_to, 4'b0000, master_to, 2'd0);
    check("to_long_hold", grant, 4'b0001, master, 2'd0);
    step();
    check("to_regrant", grant_to, 4'b0001, master_to, 2'd0);

    // A locked TRANSCOMPLETE restarts the timeout count.
    for (int i = 0; i < 3; i++) step();
    drive(1'b1, 4'b0001, 1'b1, 2'b10, 2'b00, 1'b1);
    step();
    check("to_lock_tc", grant_to, 4'b0001, master_to, 2'd0);
    drive(1'b1, 4'b0001, 1'b1, 2'b10, 2'b00, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step();
      check("to_lock_hold", grant_to, 4'b0001, master_to, 2'd0);
    end
    step();
    check("to_lock_rel", grant_to, 4'b0000, master_to, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
